// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage with a PC register, a 2-entry {pc, instr}
//            queue toward decode, redirect flush and a memory-stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_waitrequest,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic [15:0] stall_cnt
);

    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];
    logic [15:0] r_stall_cnt;

    logic        w_push;
    logic        w_pop;
    logic        w_stall;

    assign imem_addr = r_pc;
    assign imem_read = !rst && !redirect_valid && (r_count != 2'd2);
    assign if_valid  = !rst && (r_count != 2'd0);
    assign if_pc     = r_q_pc[r_head];
    assign if_instr  = r_q_instr[r_head];
    assign stall_cnt = r_stall_cnt;

    // imem_read already folds in rst/redirect, so push never fires during a flush
    assign w_push  = imem_read && !imem_waitrequest;
    assign w_pop   = if_valid && id_ready && !redirect_valid;
    assign w_stall = imem_read && imem_waitrequest;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_count     <= 2'd0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (redirect_valid) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
                r_pc    <= redirect_pc & ~32'h0000_0003;
            end else begin
                if (w_push) begin
                    r_tail <= ~r_tail;
                    r_pc   <= r_pc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage carries no reset; occupancy is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_pc;
            r_q_instr[r_tail] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port redirect_valid  input  1  branch/jump redirect request from execute.
REQ-005 SHALL have port redirect_pc  input  32  redirect target address.
REQ-006 SHALL have port imem_addr  output  32  fetch byte address to instruction memory.
REQ-007 SHALL have port imem_read  output  1  fetch request strobe.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid in any cycle with imem_waitrequest=0.
REQ-009 SHALL have port imem_waitrequest  input  1  memory/cache busy; request not accepted while high.
REQ-010 SHALL have port if_valid  output  1  fetched instruction available to decode.
REQ-011 SHALL have port if_instr  output  32  instruction at queue head.
REQ-012 SHALL have port if_pc  output  32  PC of instruction at queue head.
REQ-013 SHALL have port id_ready  input  1  decode accepts head this cycle.
REQ-014 SHALL have port stall_cnt  output  16  count of cycles with imem_read=1 and imem_waitrequest=1.

Function
REQ-015 SHALL hold a 32-bit fetch PC register pc; imem_addr SHALL equal pc combinationally.
REQ-016 SHALL contain a 2-entry FIFO of {pc, instr} pairs with head/tail pointers and a 2-bit count (0..2).
REQ-017 imem_read SHALL be 1 iff rst=0, redirect_valid=0, and count<2.
REQ-018 Accept SHALL occur in a cycle with imem_read=1 and imem_waitrequest=0: push {pc, imem_rdata} at tail; pc <= pc+4.
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 While imem_waitrequest=1, pc and FIFO contents SHALL hold; imem_read SHALL stay asserted (address stable) until accept or redirect.
REQ-021 if_valid SHALL equal (count!=0); if_instr/if_pc SHALL be the head entry (don't-care when count=0).
REQ-022 Pop SHALL occur when if_valid=1 and id_ready=1; head advances.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; FIFO order preserved.
REQ-024 count=2 with pop in same cycle SHALL NOT push (imem_read already 0 per REQ-017); refill starts next cycle.
REQ-025 redirect_valid=1 SHALL have top priority: count <= 0, pointers <= 0, pc <= {redirect_pc[31:2],2'b00}; no push, pop ignored, if_valid output that cycle still reflects pre-flush state but SHALL NOT be consumed as valid by the flush logic.
REQ-026 First fetch after redirect SHALL issue the cycle after redirect_valid deasserts or on the next cycle if redirect is a single-cycle pulse; back-to-back redirects use the last redirect_pc.
REQ-027 stall_cnt SHALL increment by 1 per cycle with imem_read=1 and imem_waitrequest=1, saturating at 16'hFFFF; redirect SHALL NOT clear it.
REQ-028 Sustained throughput SHALL be one instruction per cycle when imem_waitrequest=0 and id_ready=1.

Reset
REQ-029 On rst=1 at a rising edge: pc <= RESET_PC, count <= 0, pointers <= 0, stall_cnt <= 0.
REQ-030 During rst=1: imem_read=0, if_valid=0, imem_addr=current pc; imem_rdata/waitrequest ignored.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL override all other activity; first request issues the cycle after rst deasserts at RESET_PC.

Verification
REQ-032 Reset release, waitrequest=0, id_ready=1, memory word[i]=i -> imem_addr 0,4,8,... one per cycle; if_instr 0,1,2 with if_pc 0,4,8 starting one cycle after first accept.
REQ-033 id_ready=0 for 5 cycles -> exactly 2 entries queued (pc 0,4), imem_read=0, pc=8 held; id_ready=1 -> entries drain in order, fetch of 8 resumes.
REQ-034 waitrequest=1 for 3 cycles at pc=0x10 -> imem_addr stays 0x10, stall_cnt=3, no push; release -> instr at 0x10 delivered.
REQ-035 With 2 entries queued, redirect_valid=1 redirect_pc=0x103 -> next cycle count=0, if_valid=0, imem_addr=0x100; following instr at 0x100 delivered first.
REQ-036 redirect to 0xFFFF_FFFC, continuous fetch -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-037 rst=1 asserted while waitrequest=1 and count=1 -> next cycle if_valid=0, stall_cnt=0, pc=RESET_PC.
